pwrcap_throttle_ctrl: RTL and testbench

Parametrised power-capping throttle controller for the power-sequencing domain. It generates per-CPU PROCHOT# driver enables with a programmable PWM duty cycle, and per-channel memory throttle requests. It also runs a debounced E-brake state machine over an arbitrary number of PSUs, with a recovery hold-off and sticky per-PSU cause bits. It sits beside the power-button/LED logic and feeds the CPU PROCHOT# open-collector drivers and the memory FORCEPR lines.

---
 rtl/pwrcap_throttle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pwrcap_throttle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwrcap_throttle_ctrl.sv
// Power-capping throttle controller: PWM-gated PROCHOT# enables, per-channel memory
// throttle, and a debounced per-PSU E-brake state machine with recovery hold-off.
module pwrcap_throttle_ctrl #(
  parameter int NUMBER_OF_CPUS    = 2,
  parameter int NUMBER_OF_CHANNEL = 4,
  parameter int NUMBER_OF_PSU     = 2,
  parameter int DUTY_W            = 4,
  parameter int DEB_TICKS         = 4,
  parameter int HOLD_TICKS        = 8
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         t30p5us,
  input  logic [NUMBER_OF_CPUS-1:0]    vr_hot_n,
  input  logic                         pm_stpclk,
  input  logic                         sw_stpclk,
  input  logic                         forcepr_mask,
  input  logic [DUTY_W-1:0]            duty_cfg,
  input  logic                         ddr_pwrcap_enable,
  input  logic                         ddr_pwrcap_sw_therm,
  input  logic [NUMBER_OF_CHANNEL-1:0] ddr_pwrcap_throttle,
  input  logic [NUMBER_OF_CHANNEL-1:0] dimm_alert,
  input  logic                         ebrake_en,
  input  logic [NUMBER_OF_PSU-1:0]     ps_ac_ok,
  input  logic                         ebrake_clr,
  output logic [NUMBER_OF_CPUS-1:0]    prochot_outen,
  output logic [NUMBER_OF_CHANNEL-1:0] ddr_pwrcap_assert_ch,
  output logic                         ebrake_state,
  output logic [NUMBER_OF_PSU-1:0]     ebrake_cause
);

  localparam int DEB_W  = 8;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {ST_NORMAL, ST_BRAKE, ST_HOLD} state_t;

  state_t                         r_state, w_state_nxt;
  logic [NUMBER_OF_CPUS-1:0]      r_vr_meta, r_vr_sync;
  logic [NUMBER_OF_PSU-1:0]       r_ac_meta, r_ac_sync;
  logic [DUTY_W-1:0]              r_pwm_cnt;
  logic [NUMBER_OF_PSU-1:0]       r_q_ok;
  logic [DEB_W-1:0]               r_deb_cnt [NUMBER_OF_PSU];
  logic [HOLD_W-1:0]              r_hold_cnt;
  logic [NUMBER_OF_CPUS-1:0]      r_prochot;
  logic [NUMBER_OF_CHANNEL-1:0]   r_assert_ch;
  logic [NUMBER_OF_PSU-1:0]       r_cause;
  logic [NUMBER_OF_CHANNEL-1:0]   w_vr_hot_ch;
  logic                           w_pwm_on;
  logic                           w_event;
  logic                           w_all_ok;
  logic                           w_hold_done;
  logic                           w_ebrake_state;

  // Synchronisers idle at 1 so a reset never looks like VR-hot or AC loss.
  // NOTE: non-blocking assignments let every flop sample pre-edge values, so the
  // two synchroniser stages really form a pipeline.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_vr_meta <= '1;
      r_vr_sync <= '1;
      r_ac_meta <= '1;
      r_ac_sync <= '1;
    end else begin
      r_vr_meta <= vr_hot_n;
      r_vr_sync <= r_vr_meta;
      r_ac_meta <= ps_ac_ok;
      r_ac_sync <= r_ac_meta;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset)        r_pwm_cnt <= '0;
    else if (t30p5us) r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
  end

  assign w_pwm_on = (duty_cfg == '0) || (r_pwm_cnt < duty_cfg);
  assign w_event  = ddr_pwrcap_enable & (ddr_pwrcap_sw_therm | pm_stpclk | w_ebrake_state);

  for (genvar k = 0; k < NUMBER_OF_CHANNEL; k++) begin : g_ch_map
    assign w_vr_hot_ch[k] = ~r_vr_sync[k % NUMBER_OF_CPUS];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_prochot   <= '0;
      r_assert_ch <= '0;
    end else begin
      r_prochot   <= forcepr_mask ? '0 :
                     ({NUMBER_OF_CPUS{pm_stpclk | w_ebrake_state}} |
                      ((~r_vr_sync | {NUMBER_OF_CPUS{sw_stpclk}}) & {NUMBER_OF_CPUS{w_pwm_on}}));
      r_assert_ch <= ddr_pwrcap_throttle | dimm_alert | w_vr_hot_ch | {NUMBER_OF_CHANNEL{w_event}};
    end
  end

  // Debounce: the counter only runs while the synchronised level disagrees with q_ok.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_q_ok <= '1;
      for (int p = 0; p < NUMBER_OF_PSU; p++) r_deb_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUMBER_OF_PSU; p++) begin
        if (r_ac_sync[p] == r_q_ok[p]) begin
          r_deb_cnt[p] <= '0;
        end else if (t30p5us) begin
          if (r_deb_cnt[p] == DEB_W'(DEB_TICKS - 1)) begin
            r_q_ok[p]    <= ~r_q_ok[p];
            r_deb_cnt[p] <= '0;
          end else begin
            r_deb_cnt[p] <= r_deb_cnt[p] + DEB_W'(1);
          end
        end
      end
    end
  end

  assign w_all_ok    = &r_q_ok;
  assign w_hold_done = t30p5us && (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1));

  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= ST_NORMAL;
    else       r_state <= w_state_nxt;
  end

  // NOTE: default assignment first, so every path drives w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (!ebrake_en) begin
      w_state_nxt = ST_NORMAL;
    end else begin
      unique case (r_state)
        ST_NORMAL: if (!w_all_ok) w_state_nxt = ST_BRAKE;
        ST_BRAKE:  if (w_all_ok)  w_state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (!w_all_ok)        w_state_nxt = ST_BRAKE;
          else if (w_hold_done) w_state_nxt = ST_NORMAL;
        end
        default:                w_state_nxt = ST_NORMAL;
      endcase
    end
  end

  always_comb begin
    w_ebrake_state = (r_state != ST_NORMAL);
  end

  // Held at zero outside HOLD, so entering HOLD always starts a fresh count.
  always_ff @(posedge sys_clk) begin
    if (reset || r_state != ST_HOLD) r_hold_cnt <= '0;
    else if (t30p5us)                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) r_cause <= '0;
    else       r_cause <= (r_cause & ~{NUMBER_OF_PSU{ebrake_clr}}) |
                          ({NUMBER_OF_PSU{ebrake_en}} & ~r_q_ok);
  end

  assign prochot_outen        = r_prochot;
  assign ddr_pwrcap_assert_ch = r_assert_ch;
  assign ebrake_state         = w_ebrake_state;
  assign ebrake_cause         = r_cause;

endmodule

// File: tb/tb_pwrcap_throttle_ctrl.sv
// Scoreboard bench: a per-edge behavioural model queues expected outputs, and a
// negedge monitor pops and compares them against the DUT.
module tb_pwrcap_throttle_ctrl;
  localparam int CPUS = 2, CH = 4, PSU = 2, DW = 4, DEB = 4, HOLD = 8;
  localparam int M_NORMAL = 0, M_BRAKE = 1, M_HOLD = 2;

  logic            sys_clk = 1'b0;
  logic            reset, t30p5us, pm_stpclk, sw_stpclk, forcepr_mask;
  logic [CPUS-1:0] vr_hot_n;
  logic [DW-1:0]   duty_cfg;
  logic            ddr_pwrcap_enable, ddr_pwrcap_sw_therm, ebrake_en, ebrake_clr;
  logic [CH-1:0]   ddr_pwrcap_throttle, dimm_alert;
  logic [PSU-1:0]  ps_ac_ok;
  logic [CPUS-1:0] prochot_outen;
  logic [CH-1:0]   ddr_pwrcap_assert_ch;
  logic            ebrake_state;
  logic [PSU-1:0]  ebrake_cause;

  always #5 sys_clk = ~sys_clk;

  pwrcap_throttle_ctrl #(
    .NUMBER_OF_CPUS(CPUS), .NUMBER_OF_CHANNEL(CH), .NUMBER_OF_PSU(PSU),
    .DUTY_W(DW), .DEB_TICKS(DEB), .HOLD_TICKS(HOLD)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .t30p5us(t30p5us), .vr_hot_n(vr_hot_n),
    .pm_stpclk(pm_stpclk), .sw_stpclk(sw_stpclk), .forcepr_mask(forcepr_mask),
    .duty_cfg(duty_cfg), .ddr_pwrcap_enable(ddr_pwrcap_enable),
    .ddr_pwrcap_sw_therm(ddr_pwrcap_sw_therm), .ddr_pwrcap_throttle(ddr_pwrcap_throttle),
    .dimm_alert(dimm_alert), .ebrake_en(ebrake_en), .ps_ac_ok(ps_ac_ok),
    .ebrake_clr(ebrake_clr), .prochot_outen(prochot_outen),
    .ddr_pwrcap_assert_ch(ddr_pwrcap_assert_ch), .ebrake_state(ebrake_state),
    .ebrake_cause(ebrake_cause)
  );

  typedef struct packed {
    logic [CPUS-1:0] prochot;
    logic [CH-1:0]   assert_ch;
    logic            ebrake;
    logic [PSU-1:0]  cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Behavioural model state
  bit [CPUS-1:0] m_vr_stage, m_vr_sync;
  bit [PSU-1:0]  m_ac_stage, m_ac_sync, m_q_ok, m_cause;
  int            m_pwm, m_mode, m_hold_ticks;
  int            m_mis_ticks [PSU];
  bit [CPUS-1:0] m_prochot;
  bit [CH-1:0]   m_assert;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // One clock edge of the reference: every rule reads the pre-edge view, so the
  // rules are applied from the outputs backwards toward the synchronisers.
  task automatic model_step();
    bit   eb_old, pwm_on, evt, any_low;
    exp_t e;
    if (reset) begin
      m_vr_stage = '1; m_vr_sync = '1; m_ac_stage = '1; m_ac_sync = '1;
      m_q_ok = '1; m_cause = '0; m_pwm = 0; m_mode = M_NORMAL; m_hold_ticks = 0;
      m_prochot = '0; m_assert = '0;
      for (int p = 0; p < PSU; p++) m_mis_ticks[p] = 0;
    end else begin
      eb_old = (m_mode != M_NORMAL);
      pwm_on = (duty_cfg == 0) || (m_pwm < int'(duty_cfg));
      for (int i = 0; i < CPUS; i++)
        m_prochot[i] = !forcepr_mask && (pm_stpclk || eb_old ||
                       ((!m_vr_sync[i] || sw_stpclk) && pwm_on));
      evt = ddr_pwrcap_enable && (ddr_pwrcap_sw_therm || pm_stpclk || eb_old);
      for (int k = 0; k < CH; k++)
        m_assert[k] = ddr_pwrcap_throttle[k] || dimm_alert[k] || !m_vr_sync[k % CPUS] || evt;
      for (int p = 0; p < PSU; p++) begin
        if (ebrake_en && !m_q_ok[p]) m_cause[p] = 1'b1;
        else if (ebrake_clr)         m_cause[p] = 1'b0;
      end
      any_low = (m_q_ok != '1);
      if (!ebrake_en) m_mode = M_NORMAL;
      else if (m_mode == M_NORMAL && any_low) m_mode = M_BRAKE;
      else if (m_mode == M_BRAKE && !any_low) begin
        m_mode = M_HOLD; m_hold_ticks = 0;
      end else if (m_mode == M_HOLD) begin
        if (any_low) m_mode = M_BRAKE;
        else if (t30p5us) begin
          m_hold_ticks++;
          if (m_hold_ticks == HOLD) m_mode = M_NORMAL;
        end
      end
      for (int p = 0; p < PSU; p++) begin
        if (m_ac_sync[p] == m_q_ok[p]) m_mis_ticks[p] = 0;
        else if (t30p5us) begin
          m_mis_ticks[p]++;
          if (m_mis_ticks[p] == DEB) begin
            m_q_ok[p] = !m_q_ok[p]; m_mis_ticks[p] = 0;
          end
        end
      end
      m_vr_sync = m_vr_stage; m_vr_stage = vr_hot_n;
      m_ac_sync = m_ac_stage; m_ac_stage = ps_ac_ok;
      if (t30p5us) m_pwm = (m_pwm + 1) % (1 << DW);
    end
    e.prochot = m_prochot; e.assert_ch = m_assert;
    e.ebrake = (m_mode != M_NORMAL); e.cause = m_cause;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    model_step();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      t30p5us = (cyc % 4 == 0);
      step();
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      t30p5us    = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      ebrake_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) ebrake_en = ~ebrake_en;
      if ($urandom_range(0, 29) == 0) forcepr_mask = ~forcepr_mask;
      if ($urandom_range(0, 29) == 0) pm_stpclk = ~pm_stpclk;
      if ($urandom_range(0, 24) == 0) sw_stpclk = ~sw_stpclk;
      if ($urandom_range(0, 49) == 0) duty_cfg = DW'($urandom);
      if ($urandom_range(0, 19) == 0) vr_hot_n = vr_hot_n ^ CPUS'($urandom);
      if ($urandom_range(0, 39) == 0) ps_ac_ok = ps_ac_ok ^ PSU'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        ddr_pwrcap_throttle = CH'($urandom) & CH'($urandom);
        dimm_alert          = CH'($urandom) & CH'($urandom);
        ddr_pwrcap_enable   = 1'($urandom);
        ddr_pwrcap_sw_therm = 1'($urandom);
      end
      step();
    end
  endtask

  // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
  always @(negedge sys_clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("prochot_outen", 8'(prochot_outen), 8'(e.prochot));
      check("ddr_pwrcap_assert_ch", 8'(ddr_pwrcap_assert_ch), 8'(e.assert_ch));
      check("ebrake_state", 8'(ebrake_state), 8'(e.ebrake));
      check("ebrake_cause", 8'(ebrake_cause), 8'(e.cause));
    end
  end

  initial begin
    reset = 1'b1; t30p5us = 1'b0; vr_hot_n = '1; pm_stpclk = 1'b0; sw_stpclk = 1'b0;
    forcepr_mask = 1'b0; duty_cfg = '0; ddr_pwrcap_enable = 1'b0; ddr_pwrcap_sw_therm = 1'b0;
    ddr_pwrcap_throttle = '0; dimm_alert = '0; ebrake_en = 1'b0; ps_ac_ok = '1; ebrake_clr = 1'b0;
    run(3);
    reset = 1'b0;
    run(4);
    // Duty-limited VR-hot on CPU0
    duty_cfg = 4'd4; vr_hot_n = 2'b10;
    run(140);
    duty_cfg = 4'd1; run(70);
    duty_cfg = 4'hF; run(70);
    vr_hot_n = 2'b11; duty_cfg = 4'd4; run(4);
    // Mask overrides stop-clock, then memory event
    pm_stpclk = 1'b1; forcepr_mask = 1'b1; run(5);
    forcepr_mask = 1'b0; run(3);
    ddr_pwrcap_enable = 1'b1; run(3);
    pm_stpclk = 1'b0; ddr_pwrcap_enable = 1'b0; run(3);
    // E-brake: short glitch, real loss, re-loss during HOLD, recovery, clear
    ebrake_en = 1'b1;
    ps_ac_ok = 2'b01; run(10);
    ps_ac_ok = 2'b11; run(30);
    ps_ac_ok = 2'b01; run(24);
    ps_ac_ok = 2'b11; run(22);
    ps_ac_ok = 2'b01; run(24);
    ps_ac_ok = 2'b11; run(80);
    ebrake_clr = 1'b1; run(1);
    ebrake_clr = 1'b0; run(3);
    // Disable during BRAKE, then reset during HOLD
    ps_ac_ok = 2'b01; run(24);
    ebrake_en = 1'b0; run(3);
    ebrake_en = 1'b1; run(3);
    ps_ac_ok = 2'b11; run(30);
    reset = 1'b1; run(2);
    reset = 1'b0; run(5);
    // Clear held across a qualified loss on PSU0
    ps_ac_ok = 2'b10; ebrake_clr = 1'b1; run(30);
    ebrake_clr = 1'b0; ps_ac_ok = 2'b11; run(60);
    run_random(2000);
    reset = 1'b0; ebrake_clr = 1'b0;
    @(negedge sys_clk);
    #1;
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
